wb_decoder: RTL and testbench

WB_DECODER -- requirements
Module: wb_decoder

---
 rtl/wb_decoder_pkg.sv | 29 ++
 rtl/wb_decoder_if.sv | 43 ++++
 rtl/wb_decoder_addr_match.sv | 19 +
 rtl/wb_decoder.sv | 181 ++++++++++++++++++
 tb/tb_wb_decoder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_decoder_pkg
// Description : Shared FSM encoding, slave count and error response word
//               for the Wishbone address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_decoder_pkg;

    localparam int          NUM_SLAVES = 4;
    localparam int          SEL_W      = $clog2(NUM_SLAVES);
    localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLAVES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_decoder_if
// Description : Upstream master request/response and shared slave bus of the
//               decoder. The decoder takes the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_decoder_if;

    logic [35:0]  m_adr_i;
    logic [31:0]  m_dat_i;
    logic [3:0]   m_sel_i;
    logic         m_we_i;
    logic         m_stb_i;
    logic         m_cyc_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o;

    logic [35:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [3:0]   s_cyc_o;
    logic [3:0]   s_stb_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_decoder_addr_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_addr_match
// Description : Masked compare of a request address against one region base.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_addr_match #(
    parameter int AW = 36
) (
    input  logic [AW-1:0] adr,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] mask,
    output logic          hit
);

    assign hit = ((adr & mask) == base);

endmodule
`default_nettype wire

// File: rtl/wb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : wb_decoder
// Description : Wishbone 1-to-4 address decoder with ack timeout and error
//               response. Optional error log under WB_DECODER_ERRLOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter logic [35:0] BASE0   = 36'h0_0000_0000,
    parameter logic [35:0] BASE1   = 36'h1_0000_0000,
    parameter logic [35:0] BASE2   = 36'h2_0000_0000,
    parameter logic [35:0] BASE3   = 36'hF_0000_0000,
    parameter logic [35:0] MASK0   = 36'hF_0000_0000,
    parameter logic [35:0] MASK1   = 36'hF_0000_0000,
    parameter logic [35:0] MASK2   = 36'hF_0000_0000,
    parameter logic [35:0] MASK3   = 36'hF_0000_0000,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WB_DECODER_ERRLOG_EN
    input  logic        err_clr,
    output logic        err_flag,
    output logic [35:0] err_adr,
    output logic [7:0]  err_cnt,
`endif
    wb_decoder_if.slave bus
);

    localparam logic [NUM_SLAVES*36-1:0] C_BASES   = {BASE3, BASE2, BASE1, BASE0};
    localparam logic [NUM_SLAVES*36-1:0] C_MASKS   = {MASK3, MASK2, MASK1, MASK0};
    localparam logic [15:0]              C_TIMEOUT = 16'(TIMEOUT);

    state_t                r_state;
    state_t                w_next;
    logic [NUM_SLAVES-1:0] w_hit;
    logic [SEL_W-1:0]      w_hit_idx;
    logic [SEL_W-1:0]      r_sel;
    logic                  w_accept;
    logic                  w_sel_ack;
    logic                  w_timeout;
    logic [15:0]           r_wait;
    logic [15:0]           w_wait_inc;
    logic                  r_m_ack;
    logic [31:0]           r_m_dat;
    logic [35:0]           r_s_adr;
    logic [31:0]           r_s_dat;
    logic [3:0]            r_s_sel;
    logic                  r_s_we;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_match
        wb_addr_match #(.AW(36)) u_match (
            .adr  (bus.m_adr_i),
            .base (C_BASES[k*36 +: 36]),
            .mask (C_MASKS[k*36 +: 36]),
            .hit  (w_hit[k])
        );
    end

    // Descending scan so the lowest hitting index is the one left standing
    always_comb begin
        w_hit_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (w_hit[k]) w_hit_idx = SEL_W'(k);
        end
    end

    // While an error ack is still on the bus the master has not yet retired
    // that request, so its held strobe must not be taken as a new one.
    assign w_accept   = bus.m_cyc_i && bus.m_stb_i && !r_m_ack;
    assign w_sel_ack  = |(bus.s_ack_i & slave_onehot(r_sel));
    assign w_wait_inc = r_wait + 16'd1;
    assign w_timeout  = (w_wait_inc == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (|w_hit) ? ACTIVE : ERR;
            ACTIVE: begin
                if (!bus.m_cyc_i)   w_next = IDLE;
                else if (w_sel_ack) w_next = RESP;
                else if (w_timeout) w_next = ERR;
            end
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_ack <= 1'b0;
            r_m_dat <= '0;
            r_s_adr <= '0;
            r_s_dat <= '0;
            r_s_sel <= '0;
            r_s_we  <= 1'b0;
            r_sel   <= '0;
            r_wait  <= '0;
        end else begin
            r_m_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_s_adr <= bus.m_adr_i;
                        r_s_dat <= bus.m_dat_i;
                        r_s_sel <= bus.m_sel_i;
                        r_s_we  <= bus.m_we_i;
                        r_sel   <= w_hit_idx;
                        r_wait  <= '0;
                    end
                end
                ACTIVE: begin
                    if (bus.m_cyc_i) begin
                        if (w_sel_ack) begin
                            r_m_dat <= bus.s_dat_i[32*r_sel +: 32];
                            r_m_ack <= 1'b1;
                        end else begin
                            r_wait  <= w_wait_inc;
                        end
                    end
                end
                ERR: begin
                    r_m_dat <= ERR_DATA;
                    r_m_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.m_ack_o = r_m_ack;
    assign bus.m_dat_o = r_m_dat;
    assign bus.s_adr_o = r_s_adr;
    assign bus.s_dat_o = r_s_dat;
    assign bus.s_sel_o = r_s_sel;
    assign bus.s_we_o  = r_s_we;
    assign bus.s_cyc_o = (r_state == ACTIVE) ? slave_onehot(r_sel) : '0;
    assign bus.s_stb_o = (r_state == ACTIVE) ? slave_onehot(r_sel) : '0;

`ifdef WB_DECODER_ERRLOG_EN
    logic        w_err_entry;
    logic [35:0] w_err_adr;
    logic        r_err_flag;
    logic [35:0] r_err_adr;
    logic [7:0]  r_err_cnt;

    // Unmapped requests enter ERR straight from IDLE, before r_s_adr loads
    assign w_err_entry = (w_next == ERR) && (r_state != ERR);
    assign w_err_adr   = (r_state == IDLE) ? bus.m_adr_i : r_s_adr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_flag <= 1'b0;
            r_err_adr  <= '0;
            r_err_cnt  <= '0;
        end else if (w_err_entry) begin
            r_err_flag <= 1'b1;
            r_err_adr  <= w_err_adr;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_adr  <= '0;
            r_err_cnt  <= '0;
        end
    end

    assign err_flag = r_err_flag;
    assign err_adr  = r_err_adr;
    assign err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_decoder
// Description : Self-checking bench for wb_decoder against a transaction-level
//               reference model (decode, latency, data, error log).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_decoder;

    localparam int          T        = 8;
    localparam logic [31:0] EXP_ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_decoder_if bus();

`ifdef WB_DECODER_ERRLOG_EN
    logic        err_clr;
    logic        err_flag;
    logic [35:0] err_adr;
    logic [7:0]  err_cnt;
`endif

    wb_decoder #(.TIMEOUT(T)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef WB_DECODER_ERRLOG_EN
        .err_clr  (err_clr),
        .err_flag (err_flag),
        .err_adr  (err_adr),
        .err_cnt  (err_cnt),
`endif
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference error log
    bit          m_flag;
    logic [35:0] m_eadr;
    int          m_ecnt;

    function automatic int model_decode(input logic [35:0] a);
        logic [35:0] bases [4];
        int          r;
        bases = '{36'h0_0000_0000, 36'h1_0000_0000, 36'h2_0000_0000, 36'hF_0000_0000};
        r = -1;
        for (int k = 3; k >= 0; k--)
            if ((a & 36'hF_0000_0000) == bases[k]) r = k;
        return r;
    endfunction

    // Transfer outcome from the decode/timeout rules
    task automatic model_expect(input logic [35:0] adr, input logic [127:0] lanes, input int delay,
                                output int e_lat, output logic [31:0] e_dat, output logic [3:0] e_stb,
                                output int e_cyc);
        int k;
        k = model_decode(adr);
        if (k < 0) begin
            e_lat = 2; e_dat = EXP_ERRD; e_stb = 4'b0; e_cyc = 0;
        end else if (delay < T) begin
            e_lat = 2 + delay; e_dat = lanes[32*k +: 32]; e_stb = 4'(1 << k); e_cyc = delay + 1;
        end else begin
            e_lat = T + 2; e_dat = EXP_ERRD; e_stb = 4'(1 << k); e_cyc = T;
        end
        if (k < 0 || delay >= T) begin
            m_flag = 1'b1;
            m_eadr = adr;
            if (m_ecnt < 255) m_ecnt++;
        end
    endtask

    task automatic do_xfer(input logic [35:0] adr, input logic we, input logic [127:0] lanes,
                           input int ack_delay, input int abort_after, input bit noise, input bit clr_at_req,
                           output int lat, output logic [31:0] rdat, output logic [3:0] stb_or,
                           output int stb_cycles, output logic [3:0] stb_at_ack, output logic [35:0] adr_seen);
        int       tail;
        bit       done;
        logic [3:0] ack;
        lat = -1; rdat = '0; stb_or = '0; stb_cycles = 0; stb_at_ack = '0; adr_seen = '0;
        tail = -1; done = 1'b0;
        @(negedge clk);
        bus.m_adr_i = adr;
        bus.m_dat_i = $urandom;
        bus.m_sel_i = 4'($urandom_range(0, 15));
        bus.m_we_i  = we;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.s_dat_i = lanes;
        bus.s_ack_i = '0;
`ifdef WB_DECODER_ERRLOG_EN
        err_clr = clr_at_req;
`endif
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
`ifdef WB_DECODER_ERRLOG_EN
            err_clr = 1'b0;
`endif
            if (bus.m_ack_o === 1'b1) begin
                lat = c; rdat = bus.m_dat_o; stb_at_ack = bus.s_stb_o; done = 1'b1;
            end else begin
                ack = '0;
                if (bus.s_stb_o != 4'b0) begin
                    if (stb_cycles == 0) adr_seen = bus.s_adr_o;
                    stb_or |= bus.s_stb_o;
                    if (stb_cycles == ack_delay) ack = bus.s_stb_o;
                    stb_cycles++;
                end
                if (noise) ack |= 4'($urandom_range(0, 15)) & ~bus.s_stb_o;
                bus.s_ack_i = ack;
                if (abort_after > 0 && stb_cycles == abort_after && tail < 0) begin
                    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; tail = 6;
                end else if (tail > 0) begin
                    tail--;
                end
                if (tail == 0) done = 1'b1;
            end
        end
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.m_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.m_ack_o); end
        n_cmp++; if (bus.m_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_mdat: got %h want 0", bus.m_dat_o); end
        n_cmp++; if ({bus.s_cyc_o, bus.s_stb_o} !== 8'h0) begin n_bad++; $display("FAIL reset_cycstb: got %h want 0", {bus.s_cyc_o, bus.s_stb_o}); end
        n_cmp++; if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o} !== 73'h0) begin
            n_bad++; $display("FAIL reset_sreq: got adr %h dat %h want 0", bus.s_adr_o, bus.s_dat_o); end
`ifdef WB_DECODER_ERRLOG_EN
        n_cmp++; if ({err_flag, err_adr, err_cnt} !== 45'h0) begin n_bad++; $display("FAIL reset_errlog: got %b/%h/%0d want 0", err_flag, err_adr, err_cnt); end
`endif
        rst = 1'b0;
        m_flag = 1'b0; m_eadr = '0; m_ecnt = 0;
    endtask

    task automatic check_errlog(input string tag);
`ifdef WB_DECODER_ERRLOG_EN
        n_cmp++;
        if (err_flag !== m_flag || err_adr !== m_eadr || err_cnt !== 8'(m_ecnt)) begin
            n_bad++;
            $display("FAIL %s_errlog: got %b/%h/%0d want %b/%h/%0d", tag, err_flag, err_adr, err_cnt, m_flag, m_eadr, m_ecnt);
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic test_read_slave1();
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as; logic [127:0] lanes;
        lanes = {$urandom, $urandom, $urandom, $urandom};
        lanes[63:32] = 32'h12345678;
        do_xfer(36'h1_0000_0010, 1'b0, lanes, 3, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        n_cmp++; if (so !== 4'b0010) begin n_bad++; $display("FAIL rd1_stb: got %b want 0010", so); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL rd1_lat: got %0d want 5", lat); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL rd1_data: got %h want 12345678", rd); end
        n_cmp++; if (as !== 36'h1_0000_0010) begin n_bad++; $display("FAIL rd1_sadr: got %h want 100000010", as); end
        n_cmp++; if (sa !== 4'b0) begin n_bad++; $display("FAIL rd1_stb_resp: got %b want 0", sa); end
        @(negedge clk);
        n_cmp++; if (bus.m_ack_o !== 1'b0) begin n_bad++; $display("FAIL rd1_ack_once: got %b want 0", bus.m_ack_o); end
    endtask

    task automatic test_unmapped_write();
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as;
        do_xfer(36'h5_0000_0000, 1'b1, {4{$urandom}}, 0, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        m_flag = 1'b1; m_eadr = 36'h5_0000_0000; m_ecnt++;
        n_cmp++; if (so !== 4'b0) begin n_bad++; $display("FAIL unm_stb: got %b want 0", so); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL unm_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== EXP_ERRD) begin n_bad++; $display("FAIL unm_data: got %h want deadbeef", rd); end
        check_errlog("unm");
    endtask

    task automatic test_timeout();
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as;
        do_xfer(36'h0_0000_1234, 1'b0, {4{$urandom}}, 1000, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        m_flag = 1'b1; m_eadr = 36'h0_0000_1234; m_ecnt++;
        n_cmp++; if (cyc !== T) begin n_bad++; $display("FAIL to_stbcyc: got %0d want %0d", cyc, T); end
        n_cmp++; if (lat !== T + 2) begin n_bad++; $display("FAIL to_lat: got %0d want %0d", lat, T + 2); end
        n_cmp++; if (rd !== EXP_ERRD) begin n_bad++; $display("FAIL to_data: got %h want deadbeef", rd); end
        check_errlog("to");
    endtask

    task automatic clear_log();
`ifdef WB_DECODER_ERRLOG_EN
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        m_flag = 1'b0; m_eadr = '0; m_ecnt = 0;
        check_errlog("clr");
`endif
    endtask

    task automatic test_ack_on_timeout();
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as; logic [127:0] lanes;
        clear_log();
        lanes = {$urandom, $urandom, $urandom, $urandom};
        do_xfer(36'h0_0000_0ABC, 1'b0, lanes, T - 1, 0, 1'b1, 1'b0, lat, rd, so, cyc, sa, as);
        n_cmp++; if (lat !== T + 1) begin n_bad++; $display("FAIL ackto_lat: got %0d want %0d", lat, T + 1); end
        n_cmp++; if (rd !== lanes[31:0]) begin n_bad++; $display("FAIL ackto_data: got %h want %h", rd, lanes[31:0]); end
        check_errlog("ackto");
    endtask

    task automatic test_abort();
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as; logic [127:0] lanes;
        do_xfer(36'h2_0000_0100, 1'b0, {4{$urandom}}, 1000, 2, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        n_cmp++; if (lat !== -1) begin n_bad++; $display("FAIL abort_ack: got lat %0d want none", lat); end
        n_cmp++; if (cyc !== 2 || so !== 4'b0100) begin n_bad++; $display("FAIL abort_stb: got %0d cycles %b want 2 0100", cyc, so); end
        n_cmp++; if (bus.s_stb_o !== 4'b0 || bus.s_cyc_o !== 4'b0) begin n_bad++; $display("FAIL abort_drop: got %b/%b want 0", bus.s_stb_o, bus.s_cyc_o); end
        lanes = {$urandom, $urandom, $urandom, $urandom};
        do_xfer(36'h2_0000_0104, 1'b0, lanes, 1, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        n_cmp++; if (lat !== 3 || rd !== lanes[95:64]) begin n_bad++; $display("FAIL abort_next: got %0d/%h want 3/%h", lat, rd, lanes[95:64]); end
    endtask

    task automatic test_back_to_back();
        int lat, cyc, e_lat, e_cyc, k, delay; logic [31:0] rd, e_dat; logic [3:0] so, sa, e_stb;
        logic [35:0] as, a; logic [127:0] lanes;
        for (int i = 0; i < 40; i++) begin
            a = {4'h0, 32'($urandom)};
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 3))
                    0: a[35:32] = 4'h0;
                    1: a[35:32] = 4'h1;
                    2: a[35:32] = 4'h2;
                    default: a[35:32] = 4'hF;
                endcase
            end else begin
                a[35:32] = 4'($urandom_range(3, 14));
            end
            delay = $urandom_range(0, T + 1);
            lanes = {$urandom, $urandom, $urandom, $urandom};
            do_xfer(a, 1'($urandom_range(0, 1)), lanes, delay, 0, 1'b1, 1'b0, lat, rd, so, cyc, sa, as);
            model_expect(a, lanes, delay, e_lat, e_dat, e_stb, e_cyc);
            k = model_decode(a);
            n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, e_lat); end
            n_cmp++; if (rd !== e_dat) begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", i, rd, e_dat); end
            n_cmp++; if (so !== e_stb || cyc !== e_cyc) begin n_bad++; $display("FAIL rnd%0d_stb: got %b x%0d want %b x%0d", i, so, cyc, e_stb, e_cyc); end
            if (k >= 0) begin
                n_cmp++; if (as !== a) begin n_bad++; $display("FAIL rnd%0d_sadr: got %h want %h", i, as, a); end
            end
            check_errlog("rnd");
        end
    endtask

    task automatic test_rst_mid();
        bit seen_ack;
        @(negedge clk);
        bus.m_adr_i = 36'hF_0000_0040; bus.m_dat_i = $urandom; bus.m_sel_i = 4'hF; bus.m_we_i = 1'b1;
        bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.s_ack_i = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.s_stb_o !== 4'b1000) begin n_bad++; $display("FAIL rstmid_stb: got %b want 1000", bus.s_stb_o); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.m_ack_o, bus.m_dat_o, bus.s_cyc_o, bus.s_stb_o} !== 41'h0) begin
            n_bad++; $display("FAIL rstmid_out: got ack %b dat %h cyc %b stb %b want 0", bus.m_ack_o, bus.m_dat_o, bus.s_cyc_o, bus.s_stb_o); end
        n_cmp++; if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o} !== 73'h0) begin
            n_bad++; $display("FAIL rstmid_sreq: got adr %h dat %h want 0", bus.s_adr_o, bus.s_dat_o); end
        m_flag = 1'b0; m_eadr = '0; m_ecnt = 0;
        check_errlog("rstmid");
        rst = 1'b0; bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
        seen_ack = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.m_ack_o === 1'b1) seen_ack = 1'b1; end
        n_cmp++; if (seen_ack) begin n_bad++; $display("FAIL rstmid_noack: got ack 1 want 0"); end
    endtask

    task automatic test_errlog();
`ifdef WB_DECODER_ERRLOG_EN
        int lat, cyc; logic [31:0] rd; logic [3:0] so, sa; logic [35:0] as;
        do_xfer(36'h7_0000_0008, 1'b0, {4{$urandom}}, 0, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
        m_flag = 1'b1; m_eadr = 36'h7_0000_0008; m_ecnt++;
        do_xfer(36'h9_0000_0ABC, 1'b1, {4{$urandom}}, 0, 0, 1'b0, 1'b1, lat, rd, so, cyc, sa, as);
        m_flag = 1'b1; m_eadr = 36'h9_0000_0ABC; m_ecnt++;
        check_errlog("clrcoinc");
        for (int i = 0; i < 260; i++) begin
            do_xfer({4'hC, 32'($urandom)}, 1'b0, {4{$urandom}}, 0, 0, 1'b0, 1'b0, lat, rd, so, cyc, sa, as);
            m_flag = 1'b1; m_eadr = dut.bus.s_adr_o; if (m_ecnt < 255) m_ecnt++;
        end
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt: got %0d want 255", err_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = 1'b0;
        bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; bus.s_dat_i = '0; bus.s_ack_i = '0;
`ifdef WB_DECODER_ERRLOG_EN
        err_clr = 1'b0;
`endif
        test_reset();
        test_read_slave1();
        test_unmapped_write();
        test_timeout();
        test_ack_on_timeout();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        test_errlog();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
